// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the MIPS instruction-fetch stage.
package mips_fetch_pkg;

   localparam int unsigned XLEN        = 32;
   localparam int unsigned INSTR_BYTES = 4;

   localparam logic [XLEN-1:0] DEF_RESET_PC  = 32'h0000_0000;
   localparam logic [XLEN-1:0] DEF_NOP_INSTR = 32'h0000_0000;

   typedef enum logic [1:0] {
      ISSUE   = 2'd0,
      WAIT    = 2'd1,
      DISCARD = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic [XLEN-1:0] instr;
      logic [XLEN-1:0] pc4;
   } fetch_word_t;

   // Force an address onto an instruction-word boundary.
   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
      return addr & ~XLEN'(INSTR_BYTES - 1);
   endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry holding register for a fetch response that arrives while ID is stalled.
module fetch_skid_buffer
   import mips_fetch_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        push,
   input  logic        pop,
   input  logic        clear,
   input  fetch_word_t push_word,
   output logic        full,
   output fetch_word_t word
);

   // Clear wins over push, push wins over pop.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         full <= 1'b0;
         word <= '0;
      end else if (push) begin
         full <= 1'b1;
         word <= push_word;
      end else if (pop) begin
         full <= 1'b0;
      end
   end

endmodule

// File: rtl/if_fetch_stage.sv
// MIPS IF stage: owns the PC, issues single-outstanding imem requests, loads IF/ID.
module if_fetch_stage
   import mips_fetch_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC  = DEF_RESET_PC,
   parameter logic [XLEN-1:0] NOP_INSTR = DEF_NOP_INSTR
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            stall_id,
   input  logic            flush_id,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_gnt,
   input  logic            imem_rvalid,
   input  logic [XLEN-1:0] imem_rdata,
   output logic            ifid_valid,
   output logic [XLEN-1:0] ifid_instr,
   output logic [XLEN-1:0] ifid_pc4,
   output logic            fetch_busy
);

   fetch_state_e    state;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] req_pc;
   logic            kill;
   logic            grant;
   logic            deliver;
   logic            skid_full;
   fetch_word_t     skid_word;
   fetch_word_t     resp_word;

   assign kill      = redirect_valid | flush_id;
   assign imem_req  = (state == ISSUE) & ~reset & ~stall_id & ~skid_full & ~redirect_valid;
   assign imem_addr = pc;
   assign grant     = imem_req & imem_gnt;
   assign deliver   = (state == WAIT) & imem_rvalid & ~kill;
   assign resp_word = '{instr: imem_rdata, pc4: req_pc + XLEN'(INSTR_BYTES)};
   assign fetch_busy = (state != ISSUE);

   fetch_skid_buffer u_skid (
      .clk       (clk),
      .reset     (reset),
      .push      (deliver & stall_id),
      .pop       (~kill & ~stall_id & skid_full),
      .clear     (kill),
      .push_word (resp_word),
      .full      (skid_full),
      .word      (skid_word)
   );

   // Fetch FSM and PC; a response in DISCARD or at reset is dropped.
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= ISSUE;
         pc     <= RESET_PC;
         req_pc <= RESET_PC;
      end else begin
         case (state)
            ISSUE: begin
               if (grant) begin
                  state  <= WAIT;
                  req_pc <= pc;
               end
            end
            WAIT: begin
               if (imem_rvalid)
                  state <= ISSUE;
               else if (kill)
                  state <= DISCARD;
            end
            DISCARD: begin
               if (imem_rvalid)
                  state <= ISSUE;
            end
            default: state <= ISSUE;
         endcase

         if (redirect_valid)
            pc <= word_align(redirect_pc);
         else if (grant)
            pc <= pc + XLEN'(INSTR_BYTES);
      end
   end

   // IF/ID register: kill beats stall, skidded word beats a fresh response.
   always_ff @(posedge clk) begin
      if (reset) begin
         ifid_valid <= 1'b0;
         ifid_instr <= NOP_INSTR;
         ifid_pc4   <= '0;
      end else if (kill) begin
         ifid_valid <= 1'b0;
         ifid_instr <= NOP_INSTR;
      end else if (stall_id) begin
         ifid_valid <= ifid_valid;
      end else if (skid_full) begin
         ifid_valid <= 1'b1;
         ifid_instr <= skid_word.instr;
         ifid_pc4   <= skid_word.pc4;
      end else if (deliver) begin
         ifid_valid <= 1'b1;
         ifid_instr <= resp_word.instr;
         ifid_pc4   <= resp_word.pc4;
      end else begin
         ifid_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios then random traffic against a transaction-level model.
module tb_if_fetch_stage;

   localparam logic [31:0] NOP = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset, stall_id, flush_id, redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req, imem_gnt, imem_rvalid;
   logic [31:0] imem_addr, imem_rdata;
   logic        ifid_valid, fetch_busy;
   logic [31:0] ifid_instr, ifid_pc4;

   int checks = 0;
   int errors = 0;

   // memory model: one outstanding request, latency lat cycles after grant
   logic        want_gnt;
   int          lat;
   bit          mem_busy;
   int          mem_cnt;
   logic [31:0] mem_addr;

   // reference model of the fetch stage
   logic [31:0] m_pc, m_req_pc, m_instr, m_pc4;
   bit          m_out, m_kill, m_v;
   logic [63:0] m_skid[$];

   if_fetch_stage dut (
      .clk(clk), .reset(reset), .stall_id(stall_id), .flush_id(flush_id),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .ifid_valid(ifid_valid), .ifid_instr(ifid_instr), .ifid_pc4(ifid_pc4),
      .fetch_busy(fetch_busy)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B9) ^ 32'h1357_9BDF;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pc = 32'h0; m_req_pc = 32'h0; m_instr = NOP; m_pc4 = 32'h0;
      m_out = 0; m_kill = 0; m_v = 0;
      m_skid.delete();
   endtask

   // One clock: drive memory side, compare against the model, advance both.
   task automatic step();
      logic        er, grant, kill, dlv, s_req, s_gnt, s_rv;
      logic [31:0] s_addr;
      logic [63:0] w;
      imem_gnt    = want_gnt && !mem_busy;
      imem_rvalid = mem_busy && (mem_cnt == 0);
      imem_rdata  = imem_rvalid ? mem_word(mem_addr) : $urandom;
      #1;
      er = !reset && !m_out && !stall_id && (m_skid.size() == 0) && !redirect_valid;
      check("imem_req",   32'(imem_req),   32'(er));
      check("imem_addr",  imem_addr,       m_pc);
      check("fetch_busy", 32'(fetch_busy), 32'(m_out));
      check("ifid_valid", 32'(ifid_valid), 32'(m_v));
      if (m_v) begin
         check("ifid_instr", ifid_instr, m_instr);
         check("ifid_pc4",   ifid_pc4,   m_pc4);
      end
      s_req = imem_req; s_gnt = imem_gnt; s_rv = imem_rvalid; s_addr = imem_addr;
      @(posedge clk);
      if (reset) begin
         model_reset();
      end else begin
         grant = er && s_gnt;
         kill  = redirect_valid || flush_id;
         dlv   = m_out && !m_kill && s_rv && !kill;
         w     = {mem_word(m_req_pc), m_req_pc + 32'd4};
         if (kill) begin
            m_v = 0; m_instr = NOP; m_skid.delete();
         end else if (stall_id) begin
            if (dlv) m_skid.push_back(w);
         end else if (m_skid.size() > 0) begin
            w = m_skid.pop_front();
            m_instr = w[63:32]; m_pc4 = w[31:0]; m_v = 1;
         end else if (dlv) begin
            m_instr = w[63:32]; m_pc4 = w[31:0]; m_v = 1;
         end else begin
            m_v = 0;
         end
         if (m_out && s_rv) m_out = 0;
         else if (m_out && kill) m_kill = 1;
         if (grant) begin
            m_out = 1; m_kill = 0; m_req_pc = m_pc;
         end
         if (redirect_valid) m_pc = redirect_pc & ~32'd3;
         else if (grant) m_pc = m_pc + 32'd4;
      end
      if (s_rv) mem_busy = 0;
      else if (mem_busy) mem_cnt--;
      if (s_req && s_gnt) begin
         mem_busy = 1; mem_cnt = lat - 1; mem_addr = s_addr;
      end
      #1;
   endtask

   initial begin
      reset = 1; stall_id = 0; flush_id = 0; redirect_valid = 0; redirect_pc = 32'h0;
      imem_gnt = 0; imem_rvalid = 0; imem_rdata = 32'h0;
      want_gnt = 1; lat = 1; mem_busy = 0; mem_cnt = 0; mem_addr = 32'h0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;

      // reset state
      step();
      check("rst_valid", 32'(ifid_valid), 32'h0);
      check("rst_instr", ifid_instr, NOP);
      check("rst_pc4",   ifid_pc4,   32'h0);
      check("rst_pc",    imem_addr,  32'h0);
      reset = 0;

      // back-to-back fetches with single-cycle memory
      for (int i = 1; i <= 3; i++) begin
         step(); step();
         check("seq_valid", 32'(ifid_valid), 32'h1);
         check("seq_pc4",   ifid_pc4,        32'(4 * i));
         check("seq_addr",  imem_addr,       32'(4 * i));
      end

      // response lands while ID stalls for 3 cycles
      step();
      stall_id = 1;
      repeat (3) step();
      check("stall_valid", 32'(ifid_valid), 32'h0);
      stall_id = 0;
      step();
      check("skid_valid", 32'(ifid_valid), 32'h1);
      check("skid_pc4",   ifid_pc4,        32'h10);
      check("skid_instr", ifid_instr,      mem_word(32'hC));

      // redirect during WAIT drops the in-flight response
      lat = 3;
      step();
      redirect_valid = 1; redirect_pc = 32'h0000_0100;
      step();
      redirect_valid = 0; lat = 1;
      check("redir_valid", 32'(ifid_valid), 32'h0);
      check("redir_pc",    imem_addr,       32'h100);
      repeat (4) step();
      check("redir_tgt_valid", 32'(ifid_valid), 32'h1);
      check("redir_tgt_pc4",   ifid_pc4,        32'h104);

      // redirect + stall with the skid buffer full
      step();
      stall_id = 1;
      step();
      redirect_valid = 1; redirect_pc = 32'h0000_0203;
      step();
      check("rs_valid", 32'(ifid_valid), 32'h0);
      check("rs_instr", ifid_instr,      NOP);
      check("rs_pc",    imem_addr,       32'h200);
      stall_id = 0; redirect_valid = 0;
      step(); step();
      check("rs_tgt_pc4", ifid_pc4, 32'h204);

      // reset while WAIT, then a stale response
      lat = 3;
      step();
      reset = 1;
      step();
      reset = 0;
      check("rw_valid", 32'(ifid_valid), 32'h0);
      check("rw_pc",    imem_addr,       32'h0);
      step(); step();
      check("stale_valid", 32'(ifid_valid), 32'h0);
      lat = 1;
      step();
      check("rw_first_req", imem_addr, 32'h4);
      step();
      check("rw_first_pc4", ifid_pc4, 32'h4);

      // PC wrap at the top of the address space
      redirect_valid = 1; redirect_pc = 32'hFFFF_FFFC;
      step();
      redirect_valid = 0;
      step();
      check("wrap_pc", imem_addr, 32'h0);
      step();
      check("wrap_pc4",   ifid_pc4,        32'h0);
      check("wrap_valid", 32'(ifid_valid), 32'h1);

      // random traffic
      for (int i = 0; i < 800; i++) begin
         reset          = ($urandom_range(0, 99) < 2);
         stall_id       = ($urandom_range(0, 99) < 30);
         flush_id       = ($urandom_range(0, 99) < 8);
         redirect_valid = ($urandom_range(0, 99) < 8);
         redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                      : $urandom;
         want_gnt       = ($urandom_range(0, 99) < 70);
         lat            = $urandom_range(1, 3);
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
